fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FIFO write port; range 2..16.
REQ-002 Parameter FIFO_width, default 64: data word width, equal to the downstream FIFO width.
REQ-003 Port clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port req_valid  in  NUM_REQ  per-requester data valid.
REQ-006 Port req_data  in  NUM_REQ*FIFO_width  per-requester data; requester i occupies bits [i*FIFO_width +: FIFO_width].
REQ-007 Port req_last  in  NUM_REQ  marks the final beat of a requester's burst.
REQ-008 Port req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high.
REQ-009 Port fifo_full  in  1  full flag from the downstream FIFO.
REQ-010 Port fifo_in  out  FIFO_width  write data to the FIFO.
REQ-011 Port fifo_produce  out  1  write enable to the FIFO.
REQ-012 Port grant_id  out  clog2(NUM_REQ)  index of the current owner; valid while busy.
REQ-013 Port busy  out  1  high in the BURST state.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 In IDLE, if any req_valid is high, the block SHALL pick the first valid index scanning ptr+1, ptr+2, ... modulo NUM_REQ, register that index into grant_id, and enter BURST on the next edge.
REQ-016 In IDLE, all req_ready bits and fifo_produce SHALL be 0, giving exactly one bubble cycle per arbitration.
REQ-017 In BURST, req_ready[grant_id] SHALL equal ~fifo_full; all other req_ready bits SHALL be 0.
REQ-018 In BURST, fifo_produce SHALL equal req_valid[grant_id] & ~fifo_full, and fifo_in SHALL equal the slice of req_data selected by grant_id; both are combinational, with zero-cycle latency.
REQ-019 When a transfer occurs with req_last[grant_id] high, the FSM SHALL return to IDLE and load ptr with grant_id.
REQ-020 When fifo_full is high, no transfer SHALL occur, no beat SHALL be lost or duplicated, and the grant SHALL be held.
REQ-021 If the owner deasserts req_valid mid-burst, the grant SHALL be held indefinitely until its last beat; no preemption is allowed.
REQ-022 req_last on a non-transferring cycle SHALL be ignored.
REQ-023 While in IDLE, fifo_in SHALL be driven to 0.

Reset
REQ-024 On rst the block SHALL set: state=IDLE, grant_id=0, ptr=NUM_REQ-1 (so requester 0 has first priority), busy=0, req_ready=0, fifo_produce=0.
REQ-025 rst asserted mid-burst SHALL abort the burst on that edge, with no further FIFO writes.

Configuration
REQ-026 With macro ARB_BEAT_COUNT_EN defined, the block SHALL add output beat_cnt (NUM_REQ*16 bits).
REQ-027 Each 16-bit field of beat_cnt SHALL count that requester's transferred beats, saturate at 0xFFFF, and clear on rst.
REQ-028 Without ARB_BEAT_COUNT_EN, the beat_cnt port and its counters SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package arb_pkg SHALL hold: the state enum (IDLE, BURST), the NUM_REQ default, the FIFO_width default, and the beat-counter width constant (16).
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and ptr, and outputs any and idx.

Verification
REQ-031 Single requester: req 2 sends 3 beats (last on beat 3), FIFO not full -> one IDLE bubble, then 3 consecutive fifo_produce pulses with data in order; then IDLE with ptr=2.
REQ-032 Round-robin: all 4 requesters continuously valid, 1-beat bursts, after reset -> grant order 0,1,2,3,0, with one bubble cycle between grants.
REQ-033 Backpressure: fifo_full high for 5 cycles mid-burst -> req_ready low and fifo_produce 0 for those 5 cycles; the FIFO receives all beats exactly once, in order.
REQ-034 Gap and reset: owner drops valid for 3 cycles -> grant held, with no other requester readied; rst pulsed mid-burst -> IDLE next cycle, and requester 0 is granted first afterwards.
REQ-035 With ARB_BEAT_COUNT_EN: 70000 beats from requester 1 -> beat_cnt[1]=0xFFFF and all other fields 0; rst -> all fields 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF    = 4;
    localparam int FIFO_WIDTH_DEF = 64;
    localparam int BEAT_CNT_W     = 16;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req scanning ptr+1, ptr+2, ... modulo N.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is pending.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                any = 1'b1;
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; optional per-requester beat counters under ARB_BEAT_COUNT_EN.
// Latency: one IDLE bubble per arbitration, then data/produce are combinational from the owner's inputs.
// Backpressure: fifo_full drops the owner's req_ready and fifo_produce; the grant is held until its last beat.
module fifo_write_arbiter
    import arb_pkg::*;
#(
    parameter int  NUM_REQ    = NUM_REQ_DEF,
    parameter int  FIFO_width = FIFO_WIDTH_DEF,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_width-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic [FIFO_width-1:0]         fifo_in,
    output logic                          fifo_produce,
    output logic [IDX_W-1:0]              grant_id,
`ifdef ARB_BEAT_COUNT_EN
    output logic [NUM_REQ*BEAT_CNT_W-1:0] beat_cnt,
`endif
    output logic                          busy
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    logic             own_valid;
    logic             own_last;
    logic [FIFO_width-1:0] own_data;

    rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Mux the current owner's valid/last/data using constant slices.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDX_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*FIFO_width +: FIFO_width];
            end
        end
    end

    // Next-state and outputs; reset suppresses any write in the cycle it is asserted.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        req_ready    = '0;
        fifo_produce = 1'b0;
        fifo_in      = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    state_d    = BURST;
                end
            end
            BURST: begin
                fifo_in = own_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id_q == IDX_W'(i)) begin
                        req_ready[i] = ~fifo_full & ~rst;
                    end
                end
                fifo_produce = own_valid & ~fifo_full & ~rst;
                if (fifo_produce && own_last) begin
                    state_d = IDLE;
                    ptr_d   = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; ptr resets to the last index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q == BURST);

`ifdef ARB_BEAT_COUNT_EN
    logic [NUM_REQ*BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Saturating per-requester count of accepted beats.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fifo_produce && grant_id_q == IDX_W'(i) &&
                beat_cnt_q[i*BEAT_CNT_W +: BEAT_CNT_W] != {BEAT_CNT_W{1'b1}}) begin
                beat_cnt_d[i*BEAT_CNT_W +: BEAT_CNT_W] =
                    beat_cnt_q[i*BEAT_CNT_W +: BEAT_CNT_W] + BEAT_CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, FIFO_width=64); beat counters exercised when ARB_BEAT_COUNT_EN is defined.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 2 units after it.
// Backpressure: fifo_full driven directly; writes recorded at the falling edge.
module tb_fifo_write_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic [63:0]  fifo_in;
    logic         fifo_produce;
    logic [1:0]   grant_id;
    logic         busy;
`ifdef ARB_BEAT_COUNT_EN
    logic [63:0]  beat_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] wr_q[$];
    logic        mon_en = 1'b1;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .FIFO_width (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_in      (fifo_in),
        .fifo_produce (fifo_produce),
        .grant_id     (grant_id),
`ifdef ARB_BEAT_COUNT_EN
        .beat_cnt     (beat_cnt),
`endif
        .busy         (busy)
    );

    // Record every beat the FIFO would accept on the coming edge.
    always @(negedge clk) begin
        if (mon_en && fifo_produce) wr_q.push_back(fifo_in);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic put(input int i, input logic [63:0] v);
        req_data[i*64 +: 64] = v;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    logic [63:0] exp_wr[$];

    task automatic check_writes(input string tag);
        check({tag, "_cnt"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            check(tag, wr_q[i], exp_wr[i]);
    endtask

    initial begin
        req_data = '0;
        do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        check("rst_busy",  64'(busy),         64'd0);
        check("rst_ready", 64'(req_ready),    64'd0);
        check("rst_prod",  64'(fifo_produce), 64'd0);
        check("rst_grant", 64'(grant_id),     64'd0);
        check("rst_fin",   fifo_in,           64'd0);

        // Single requester, three-beat burst.
        wr_q.delete();
        put(2, 64'h1111);
        req_valid = 4'b0100;
        settle;
        check("t1_bub_prod",  64'(fifo_produce), 64'd0);
        check("t1_bub_ready", 64'(req_ready),    64'd0);
        check("t1_bub_fin",   fifo_in,           64'd0);
        tick; settle;
        check("t1_busy",  64'(busy),         64'd1);
        check("t1_grant", 64'(grant_id),     64'd2);
        check("t1_ready", 64'(req_ready),    64'b0100);
        check("t1_prod0", 64'(fifo_produce), 64'd1);
        check("t1_fin0",  fifo_in,           64'h1111);
        tick; put(2, 64'h2222); settle;
        check("t1_fin1",  fifo_in,           64'h2222);
        tick; put(2, 64'h3333); req_last = 4'b0100; settle;
        check("t1_prod2", 64'(fifo_produce), 64'd1);
        tick; req_valid = '0; req_last = '0; settle;
        check("t1_idle",  64'(busy),         64'd0);
        exp_wr = '{64'h1111, 64'h2222, 64'h3333};
        check_writes("t1_wr");
        // ptr now 2: with 1 and 3 pending, 3 is next.
        put(1, 64'h0101); put(3, 64'h0303);
        req_valid = 4'b1010; req_last = 4'b1010;
        tick; settle;
        check("t1_ptr2",  64'(grant_id),     64'd3);
        tick; req_valid = '0; req_last = '0;

        // Round robin with all requesters always valid and 1-beat bursts.
        do_reset;
        for (int i = 0; i < 4; i++) put(i, 64'hA0 + 64'(i));
        req_valid = 4'hF; req_last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            settle;
            check("t2_bubble", 64'(busy), 64'd0);
            tick; settle;
            check("t2_grant", 64'(grant_id), 64'(k % 4));
            check("t2_fin",   fifo_in,       64'hA0 + 64'(k % 4));
            tick;
        end
        req_valid = '0; req_last = '0;

        // Backpressure for 5 cycles mid-burst.
        do_reset;
        wr_q.delete();
        put(1, 64'hB0);
        req_valid = 4'b0010;
        tick; settle;
        check("t3_busy", 64'(busy), 64'd1);
        tick; put(1, 64'hB1); fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle;
            check("t3_full_ready", 64'(req_ready),    64'd0);
            check("t3_full_prod",  64'(fifo_produce), 64'd0);
            tick;
        end
        fifo_full = 1'b0; settle;
        check("t3_resume_ready", 64'(req_ready),    64'b0010);
        check("t3_resume_prod",  64'(fifo_produce), 64'd1);
        tick; put(1, 64'hB2);
        tick; put(1, 64'hB3); req_last = 4'b0010;
        tick; req_valid = '0; req_last = '0; settle;
        check("t3_idle", 64'(busy), 64'd0);
        exp_wr = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
        check_writes("t3_wr");

        // Owner gap with stray last, then reset mid-burst.
        do_reset;
        wr_q.delete();
        put(0, 64'hC0); put(2, 64'hC2); put(3, 64'hC3);
        req_valid = 4'b1101;
        tick; settle;
        check("t4_grant0", 64'(grant_id), 64'd0);
        tick; req_valid = 4'b1100; req_last = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            settle;
            check("t4_gap_busy",  64'(busy),         64'd1);
            check("t4_gap_grant", 64'(grant_id),     64'd0);
            check("t4_gap_ready", 64'(req_ready),    64'b0001);
            check("t4_gap_prod",  64'(fifo_produce), 64'd0);
            tick;
        end
        req_valid = 4'b1101; put(0, 64'hC1); settle;
        check("t4_back_prod", 64'(fifo_produce), 64'd1);
        tick; req_last = '0; put(1, 64'hD0); req_valid = 4'b1110; settle;
        check("t4_idle", 64'(busy), 64'd0);
        tick; settle;
        check("t4_grant1", 64'(grant_id), 64'd1);
        tick; put(1, 64'hD1); rst = 1'b1; settle;
        check("t4_rst_prod", 64'(fifo_produce), 64'd0);
        tick; rst = 1'b0; req_valid = 4'hF; settle;
        check("t4_rst_idle", 64'(busy), 64'd0);
        tick; settle;
        check("t4_after_rst_grant", 64'(grant_id), 64'd0);
        exp_wr = '{64'hC0, 64'hC1, 64'hD0};
        check_writes("t4_wr");
        req_valid = '0;
        tick;

`ifdef ARB_BEAT_COUNT_EN
        // Saturating beat counters.
        do_reset;
        mon_en = 1'b0;
        settle;
        check("t5_rst_cnt", beat_cnt, 64'd0);
        req_valid = 4'b0010;
        tick;
        repeat (10) tick;
        settle;
        check("t5_cnt10", beat_cnt, 64'h0000_0000_000A_0000);
        repeat (70000) tick;
        settle;
        check("t5_sat", beat_cnt, 64'h0000_0000_FFFF_0000);
        req_valid = '0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        check("t5_clr", beat_cnt, 64'd0);
        mon_en = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
